// File: rtl/operand_sel_pipe.sv
// Registered NUM_IN:1 operand select with valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects produce DEFAULT_VAL, raise out_err and bump a saturating error counter.
module operand_sel_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 3,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_BOTH
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             accept;
  logic             emit;
  logic             load_main_from_in;
  logic             load_main_from_skid;
  logic             load_skid;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Any select value with no matching input falls through to DEFAULT_VAL with err set.
  always_comb begin
    sel_data = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept && !emit) begin
            state_next = ST_BOTH;
          end else if (!accept && emit) begin
            state_next = ST_EMPTY;
          end
        end
        ST_BOTH: begin
          if (emit) begin
            state_next = ST_MAIN;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags decode only the state register, so in_ready never sees out_ready.
  always_comb begin
    out_valid           = (state != ST_EMPTY);
    in_ready            = (state != ST_BOTH);
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (!flush) begin
      load_main_from_in   = accept && ((state == ST_EMPTY) || (state == ST_MAIN && emit));
      load_main_from_skid = emit && (state == ST_BOTH);
      load_skid           = accept && (state == ST_MAIN) && !emit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (load_main_from_skid) begin
      out_data <= skid_data;
      out_err  <= skid_err;
    end else if (load_main_from_in) begin
      out_data <= sel_data;
      out_err  <= sel_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else if (load_skid) begin
      skid_data <= sel_data;
      skid_err  <= sel_err;
    end
  end

  // Counts every accepted bad select, even one whose item is discarded by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && sel_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/operand_sel_pipe.md
Name: operand_sel_pipe

Overview:
- Parametrised, registered successor to the datapath 3:1 select mux, used for ALU/FPU operand forwarding selection.
- Selects one of NUM_IN flattened WIDTH-bit inputs and registers the result behind a valid/ready handshake.
- Uses a 2-entry skid buffer, so in_ready is a registered signal with no combinational path from out_ready.
- Power features: output and skid registers load only on an actual transfer. Out-of-range selects are flagged, not silently passed through.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 3, number of selectable inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
DEFAULT_VAL, 0, value output when sel >= NUM_IN
CNT_W, 8, width of saturating select-error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  input index, sampled with in_valid
in_valid  input  1  upstream request valid
in_ready  output  1  block can accept this cycle
flush  input  1  synchronous pipeline flush (branch mispredict/trap)
out_data  output  WIDTH  selected, registered operand
out_err  output  1  high with out_data when the originating sel was >= NUM_IN
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts
err_cnt  output  CNT_W  saturating count of accepted out-of-range selects

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, out_err=0, skid entry empty, skid data/err=0, in_ready=1, err_cnt=0.
- Accept occurs when in_valid & in_ready. Emit occurs when out_valid & out_ready.
- Select function: data = in_data[sel*WIDTH +: WIDTH] if sel < NUM_IN. Otherwise data = DEFAULT_VAL and err = 1.
- Latency: an accepted item appears on out_data/out_valid on the next rising edge when the output register is free. Back-to-back throughput is one item per cycle with out_ready held high.
- Two storage entries, main (drives outputs) and skid:
  - Main empty, or main emitting with skid empty: accepted item loads main.
  - Main full, not emitting, skid empty: accepted item loads skid.
  - Main emitting with skid full: skid moves to main. A simultaneous accept is impossible because in_ready=0.
- in_ready = !skid_full (registered). Order is strictly FIFO; no item is lost or duplicated.
- Registers with no transfer are not written (clock-gating friendly). out_data holds its value while out_valid=0.
- flush (sync, highest priority): next edge sets out_valid=0, skid empty, in_ready=1. An accept in the flush cycle is discarded. err_cnt is not cleared by flush. out_data is not required to change.
- err_cnt increments by 1 on each accepted item with sel >= NUM_IN, including items later flushed. It saturates at 2**CNT_W-1.
- rst_n asserted mid-transfer: all state clears immediately; the in-flight item is dropped.
- Holding: out_data, out_err and out_valid stay stable while out_valid=1 & out_ready=0.

Test Plan:
- Reset, then sel=0/1/2 with inputs 0x11111111/0x22222222/0x33333333, out_ready=1 -> out_data follows one cycle later in order; out_err=0; one item per cycle.
- sel=3 with NUM_IN=3 accepted -> out_data=0x00000000, out_err=1, err_cnt=1. Repeat 300 times with CNT_W=8 -> err_cnt saturates at 255.
- Stream A,B,C with out_ready=0 -> A held in main, B in skid, in_ready=0 and C stalls. Release out_ready -> outputs A,B,C in order with no loss or duplication.
- Skid full with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle item is absent, err_cnt unchanged.
- rst_n pulsed low mid-stream (asynchronously, between edges) -> out_valid, in_ready, err_cnt take reset values immediately.
- NUM_IN=5, WIDTH=16: random sel in 0..7 with random out_ready -> scoreboard matches the reference select function, with out_err set for sel 5..7.
